// File: rtl/node_column_v3.sv
// One column of a 2-D damped wave-equation grid: pyramid initial condition, then one time step per request.
// Optional macro NODE_COLUMN_NONLINEAR_TENSION_EN adds middle-amplitude dependent tension to rho.
module node_column_v3 #(
  parameter int DATA_W = 18,
  parameter int FRAC_W = 17,
  parameter int ADDR_W = 9,
  parameter logic signed [DATA_W-1:0] RHO_MAX = 18'sd64225
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        column_size,
  input  logic [ADDR_W-1:0]        column_num,
  input  logic signed [DATA_W-1:0] pyramid_step,
  input  logic signed [DATA_W-1:0] rho,
  input  logic signed [DATA_W-1:0] g_tension,
  input  logic signed [DATA_W-1:0] eta_term,
  input  logic                     init_start,
  input  logic                     step_start,
  input  logic signed [DATA_W-1:0] u_left,
  input  logic signed [DATA_W-1:0] u_right,
  output logic [ADDR_W-1:0]        row_idx,
  output logic                     row_valid,
  output logic signed [DATA_W-1:0] u_n_out,
  output logic signed [DATA_W-1:0] middle_out,
  output logic                     busy,
  output logic                     init_done,
  output logic                     step_done
);

  localparam int WW = 2*DATA_W + 4;
  localparam logic [ADDR_W-1:0] A_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] A_THREE = ADDR_W'(2'd3);
  localparam logic signed [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};
  localparam logic signed [WW-1:0] ONE_W = {{(WW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_READ, ST_WAIT, ST_LOAD, ST_WRITE} state_t;

  function automatic logic signed [WW-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{(WW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Clamp a wide intermediate into DATA_W instead of letting it wrap.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
    if (!v[WW-1] && (|v[WW-2:DATA_W-1])) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v[WW-1] && !(&v[WW-2:DATA_W-1])) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  state_t                  state_r;
  logic                    ph_r;
  logic [ADDR_W-1:0]       row_r, n_r, c_r;
  logic signed [DATA_W-1:0] ps_r, init_val_r, nxt_r;
  logic signed [DATA_W-1:0] u_cur_r, u_up_r, u_down_r;
  logic signed [DATA_W-1:0] rd_un_r, rd_pv_r;
  logic signed [DATA_W-1:0] u_n_out_r, middle_r;
  logic                    row_valid_r, busy_r, init_done_r, step_done_r;
  logic signed [DATA_W-1:0] un_mem [0:(1<<ADDR_W)-1];
  logic signed [DATA_W-1:0] up_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]       n_in_s, c_in_s, rr_s, cr_s, dr_s, dc_s, k_s, rd_addr_s;
  logic signed [DATA_W-1:0] init_val_s, u_next_s, rho_eff_s, un_wd_s, up_wd_s;
  logic                    mem_we_s, last_row_s;
  logic signed [WW-1:0]    lap_w, rl_w, ome_w, pv_w, inner_w, fin_w;

  // Degenerate grid sizes and out-of-range column indices are folded into legal values.
  always_comb begin
    n_in_s = (column_size < A_THREE) ? A_THREE : column_size;
    c_in_s = (column_num >= n_in_s) ? (n_in_s - A_ONE) : column_num;
    last_row_s = (row_r == (n_r - A_ONE));
  end

  // Pyramid height: distance to the nearest grid edge plus one, times the step.
  always_comb begin
    rr_s = n_r - A_ONE - row_r;
    cr_s = n_r - A_ONE - c_r;
    dr_s = (row_r < rr_s) ? row_r : rr_s;
    dc_s = (c_r < cr_s) ? c_r : cr_s;
    k_s  = ((dr_s < dc_s) ? dr_s : dc_s) + A_ONE;
    init_val_s = sat(ext(ps_r) * {{(WW-ADDR_W){1'b0}}, k_s});
  end

`ifdef NODE_COLUMN_NONLINEAR_TENSION_EN
  logic signed [WW-1:0] ten_w;
  // Effective rho grows with the square of the scaled middle amplitude, capped at RHO_MAX.
  always_comb begin
    ten_w = (ext(middle_r) * ext(g_tension)) >>> FRAC_W;
    ten_w = (ten_w * ten_w) >>> FRAC_W;
    ten_w = ext(rho) + ten_w;
    if (ten_w > ext(RHO_MAX)) begin
      rho_eff_s = RHO_MAX;
    end else begin
      rho_eff_s = ten_w[DATA_W-1:0];
    end
  end
`else
  logic tension_unused_s;
  assign tension_unused_s = ^g_tension;
  // Linear model: rho is used as given.
  always_comb begin
    rho_eff_s = rho;
  end
`endif

  // Damped update; the inner sum is saturated before the final (1-eta) scaling.
  always_comb begin
    lap_w   = ext(u_left) + ext(u_right) + ext(u_up_r) + ext(u_down_r) - (ext(u_cur_r) <<< 2);
    rl_w    = (ext(rho_eff_s) * lap_w) >>> FRAC_W;
    ome_w   = ONE_W - ext(eta_term);
    pv_w    = (ome_w * ext(rd_pv_r)) >>> FRAC_W;
    inner_w = (ext(u_cur_r) <<< 1) + rl_w - pv_w;
    fin_w   = (ome_w * ext(sat(inner_w))) >>> FRAC_W;
    u_next_s = sat(fin_w);
  end

  // RAM port control: IDLE pre-reads row 0 so READ of row 0 can latch it.
  always_comb begin
    mem_we_s  = 1'b0;
    un_wd_s   = nxt_r;
    up_wd_s   = u_cur_r;
    rd_addr_s = row_r + A_ONE;
    case (state_r)
      ST_INIT: begin
        mem_we_s = ph_r;
        un_wd_s  = init_val_r;
        up_wd_s  = init_val_r;
      end
      ST_WRITE: mem_we_s  = 1'b1;
      ST_IDLE:  rd_addr_s = A_ZERO;
      default:  mem_we_s  = 1'b0;
    endcase
  end

  // u_n and u_prev storage with registered reads.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      un_mem[row_r] <= un_wd_s;
      up_mem[row_r] <= up_wd_s;
    end
    rd_un_r <= un_mem[rd_addr_s];
    rd_pv_r <= up_mem[row_r];
  end

  // Control FSM and registered status/data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;       ph_r <= 1'b0;
      row_r <= A_ZERO;          n_r <= A_THREE;       c_r <= A_ZERO;
      ps_r <= D_ZERO;           init_val_r <= D_ZERO; nxt_r <= D_ZERO;
      u_cur_r <= D_ZERO;        u_up_r <= D_ZERO;     u_down_r <= D_ZERO;
      u_n_out_r <= D_ZERO;      middle_r <= D_ZERO;
      row_valid_r <= 1'b0;      busy_r <= 1'b0;
      init_done_r <= 1'b0;      step_done_r <= 1'b0;
    end else begin
      step_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (init_start) begin
            n_r <= n_in_s;  c_r <= c_in_s;  ps_r <= pyramid_step;
            row_r <= A_ZERO;  ph_r <= 1'b0;
            init_done_r <= 1'b0;  busy_r <= 1'b1;
            state_r <= ST_INIT;
          end else if (step_start && init_done_r) begin
            row_r <= A_ZERO;  busy_r <= 1'b1;
            state_r <= ST_READ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INIT: begin
          if (!ph_r) begin
            init_val_r <= init_val_s;
            ph_r <= 1'b1;
          end else begin
            ph_r <= 1'b0;
            if (last_row_s) begin
              row_r <= A_ZERO;  init_done_r <= 1'b1;  busy_r <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              row_r <= row_r + A_ONE;
            end
          end
        end
        ST_READ: begin
          if (row_r == A_ZERO) begin
            u_cur_r  <= rd_un_r;
            u_down_r <= D_ZERO;
          end
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          u_up_r      <= last_row_s ? D_ZERO : rd_un_r;
          u_n_out_r   <= u_cur_r;
          row_valid_r <= 1'b1;
          state_r     <= ST_LOAD;
        end
        ST_LOAD: begin
          row_valid_r <= 1'b0;
          nxt_r       <= u_next_s;
          state_r     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (row_r == (n_r >> 1)) begin
            middle_r <= nxt_r;
          end
          // Slide the window: the pre-update value becomes the next row's lower neighbour.
          u_down_r <= u_cur_r;
          u_cur_r  <= u_up_r;
          if (last_row_s) begin
            row_r <= A_ZERO;  busy_r <= 1'b0;  step_done_r <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            row_r <= row_r + A_ONE;
            state_r <= ST_READ;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign row_idx    = row_r;
  assign row_valid  = row_valid_r;
  assign u_n_out    = u_n_out_r;
  assign middle_out = middle_r;
  assign busy       = busy_r;
  assign init_done  = init_done_r;
  assign step_done  = step_done_r;

endmodule

// File: tb/tb_node_column_v3.sv
// Directed bench for node_column_v3 (default build, nonlinear tension disabled).
module tb_node_column_v3;
  localparam int DW = 18;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] column_size, column_num, row_idx;
  logic [DW-1:0] pyramid_step, rho, g_tension, eta_term, u_left, u_right, u_n_out, middle_out;
  logic init_start, step_start, row_valid, busy, init_done, step_done;

  int checks = 0;
  int failures = 0;
  int lat, nv;
  logic sd, found;
  logic [AW-1:0] ri [8];
  logic [DW-1:0] uo [8];
  logic [DW-1:0] exp_a [5];
  logic [DW-1:0] acc;

  always #5 clk = ~clk;

  node_column_v3 dut (
    .clk(clk), .reset(reset), .column_size(column_size), .column_num(column_num),
    .pyramid_step(pyramid_step), .rho(rho), .g_tension(g_tension), .eta_term(eta_term),
    .init_start(init_start), .step_start(step_start), .u_left(u_left), .u_right(u_right),
    .row_idx(row_idx), .row_valid(row_valid), .u_n_out(u_n_out), .middle_out(middle_out),
    .busy(busy), .init_done(init_done), .step_done(step_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency is counted from the accepting clock edge; l = -1 if init_done never rises.
  task automatic run_init(input logic [AW-1:0] n, input logic [AW-1:0] c, input logic [DW-1:0] ps,
                          input logic also_step, output int l, output logic saw_done);
    column_size = n; column_num = c; pyramid_step = ps;
    init_start = 1'b1; step_start = also_step;
    l = -1; saw_done = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      init_start = 1'b0; step_start = 1'b0;
      if (step_done) saw_done = 1'b1;
      if (init_done) begin l = i - 1; break; end
    end
  endtask

  // Latency is counted from the cycle step_start is raised; l = -1 on timeout.
  task automatic run_step(input int limit, input logic poke, output int l);
    step_start = 1'b1; nv = 0; l = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      step_start = 1'b0;
      if (poke && i == 6) begin
        init_start = 1'b1; pyramid_step = 18'h07000;
      end else begin
        init_start = 1'b0;
      end
      if (row_valid && nv < 8) begin ri[nv] = row_idx; uo[nv] = u_n_out; nv++; end
      if (step_done) begin l = i; break; end
    end
    init_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; init_start = 1'b0; step_start = 1'b0;
    column_size = 9'd5; column_num = 9'd2; pyramid_step = 18'h0;
    rho = 18'h0; g_tension = 18'h0; eta_term = 18'h0; u_left = 18'h0; u_right = 18'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_row_valid", row_valid, 1'b0);
    chk("rst_step_done", step_done, 1'b0);
    chk("rst_row_idx", row_idx, 9'd0);
    chk("rst_u_n_out", u_n_out, 18'h0);
    chk("rst_middle", middle_out, 18'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Step before any init is ignored.
    run_step(30, 1'b0, lat);
    chk("noinit_lat", lat, -1);
    chk("noinit_rows", nv, 0);
    chk("noinit_busy", busy, 1'b0);

    // Pyramid init N=5, column 2.
    run_init(9'd5, 9'd2, 18'h00100, 1'b0, lat, sd);
    chk("init_lat", lat, 10);
    chk("init_done", init_done, 1'b1);

    // First step: strobes read back the initial column; an init request while busy is ignored.
    rho = 18'h08000; eta_term = 18'h0; u_left = 18'h0; u_right = 18'h0;
    exp_a = '{18'h00100, 18'h00200, 18'h00300, 18'h00200, 18'h00100};
    run_step(60, 1'b1, lat);
    chk("step1_lat", lat, 21);
    chk("step1_strobes", nv, 5);
    for (int i = 0; i < 5; i++) begin
      chk("step1_row_idx", ri[i], i);
      chk("step1_u_n", uo[i], exp_a[i]);
    end
    chk("step1_middle", middle_out, 18'h00100);
    chk("step1_init_done", init_done, 1'b1);

    // Second step shows the written u_next; g_tension has no effect in this build.
    g_tension = 18'h1FFFF;
    exp_a = '{18'h00080, 18'h00100, 18'h00100, 18'h00100, 18'h00080};
    run_step(60, 1'b0, lat);
    for (int i = 0; i < 5; i++) chk("step2_u_n", uo[i], exp_a[i]);
    chk("step2_middle", middle_out, 18'h3FE80);
    g_tension = 18'h0;

    // Simultaneous starts: init wins; column_num 7 >= N clamps to the edge column.
    run_init(9'd5, 9'd7, 18'h00040, 1'b1, lat, sd);
    chk("both_init_lat", lat, 10);
    chk("both_no_step_done", sd, 1'b0);
    run_step(60, 1'b0, lat);
    chk("clamp_lat", lat, 21);
    for (int i = 0; i < 5; i++) chk("clamp_u_n", uo[i], 18'h00040);

    // All-zero state stays zero.
    run_init(9'd5, 9'd2, 18'h0, 1'b0, lat, sd);
    run_step(60, 1'b0, lat);
    chk("zero_middle", middle_out, 18'h0);
    run_step(60, 1'b0, lat);
    acc = 18'h0;
    for (int i = 0; i < 5; i++) acc = acc | uo[i];
    chk("zero_rows", acc, 18'h0);
    chk("zero_middle2", middle_out, 18'h0);

    // column_size 1 behaves as 3.
    run_init(9'd1, 9'd1, 18'h00010, 1'b0, lat, sd);
    chk("small_init_lat", lat, 6);
    run_step(60, 1'b0, lat);
    chk("small_strobes", nv, 3);
    chk("small_lat", lat, 13);

    // Full-scale column and neighbours: no wrap, result stays at +max.
    rho = 18'h0FAE1; eta_term = 18'h0; u_left = 18'h1FFFF; u_right = 18'h1FFFF;
    run_init(9'd5, 9'd2, 18'h1FFFF, 1'b0, lat, sd);
    run_step(60, 1'b0, lat);
    chk("fs_middle1", middle_out, 18'h1FFFF);
    run_step(60, 1'b0, lat);
    chk("fs_row0", uo[0], 18'h1051E);
    chk("fs_row2", uo[2], 18'h1FFFF);
    chk("fs_middle2", middle_out, 18'h1FFFF);

    // Large negative Laplacian at row 0 saturates to -max instead of wrapping positive.
    u_left = 18'h20001; u_right = 18'h20001;
    run_init(9'd5, 9'd2, 18'h1FFFF, 1'b0, lat, sd);
    run_step(60, 1'b0, lat);
    run_step(60, 1'b0, lat);
    chk("neg_sat_row0", uo[0], 18'h20000);

    // Reset in the middle of row 2, then a step request is ignored until re-init.
    u_left = 18'h0; u_right = 18'h0;
    step_start = 1'b1; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      step_start = 1'b0;
      if (row_valid && row_idx == 9'd2) begin found = 1'b1; break; end
    end
    chk("mid_row2_seen", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_row_valid", row_valid, 1'b0);
    chk("mid_rst_row_idx", row_idx, 9'd0);
    chk("mid_rst_middle", middle_out, 18'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_step(30, 1'b0, lat);
    chk("post_rst_lat", lat, -1);
    chk("post_rst_rows", nv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
